// File: rtl/vec_ctrl_pkg.sv
// Shared types, opcode constants and helpers for the vector exec arbiter.
// The funct7 encodings may be overridden by an earlier definition of the same macros.
`ifndef FUNCT7_VMAC
`define FUNCT7_VMAC 7'h01
`endif
`ifndef FUNCT7_VADD
`define FUNCT7_VADD 7'h02
`endif
`ifndef FUNCT7_VSUB
`define FUNCT7_VSUB 7'h03
`endif
`ifndef FUNCT7_VMUL
`define FUNCT7_VMUL 7'h04
`endif

package vec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    localparam logic [6:0] F7_VMAC = `FUNCT7_VMAC;
    localparam logic [6:0] F7_VADD = `FUNCT7_VADD;
    localparam logic [6:0] F7_VSUB = `FUNCT7_VSUB;
    localparam logic [6:0] F7_VMUL = `FUNCT7_VMUL;

    // Wide enough for any practical TIMEOUT_CYCLES setting.
    localparam int unsigned TMO_CNT_W = 16;

    function automatic logic is_legal_funct7(input logic [6:0] funct7);
        return (funct7 == F7_VMAC) || (funct7 == F7_VADD) ||
               (funct7 == F7_VSUB) || (funct7 == F7_VMUL);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, searching circularly.
module rr_arbiter
    import vec_ctrl_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic            found;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand     = (32'(ptr_i) + off) % N;
            cand_idx = IdxW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/vector_exec_arbiter.sv
// Shares one vector exec unit between NUM_REQ requesters with round-robin grant, a response
// register held until the owner accepts it, and timeout / illegal-opcode error responses.
module vector_exec_arbiter
    import vec_ctrl_pkg::*;
#(
    parameter int unsigned VLEN           = 256,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*7-1:0]    req_funct7_i,
    input  logic [NUM_REQ*3-1:0]    req_funct3_i,
    input  logic [NUM_REQ*VLEN-1:0] req_vec_a_i,
    input  logic [NUM_REQ*VLEN-1:0] req_vec_b_i,
    input  logic [NUM_REQ*VLEN-1:0] req_vec_c_i,

    output logic [NUM_REQ-1:0]      rsp_valid_o,
    input  logic [NUM_REQ-1:0]      rsp_ready_i,
    output logic [VLEN-1:0]         rsp_result_o,
    output logic                    rsp_err_o,

    output logic                    ex_start_o,
    output logic [6:0]              ex_funct7_o,
    output logic [2:0]              ex_funct3_o,
    output logic [VLEN-1:0]         ex_vec_a_o,
    output logic [VLEN-1:0]         ex_vec_b_o,
    output logic [VLEN-1:0]         ex_vec_c_o,
    input  logic                    ex_done_i,
    input  logic [VLEN-1:0]         ex_result_i,

    output logic                    busy_o
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TMO_CNT_W-1:0] TmoLast = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    arb_state_e           state_q;
    logic [IdxW-1:0]      rr_ptr_q;
    logic [IdxW-1:0]      owner_q;
    logic [NUM_REQ-1:0]   owner_oh_q;
    logic [TMO_CNT_W-1:0] tmo_cnt_q;

    logic                 ex_start_q;
    logic [6:0]           ex_funct7_q;
    logic [2:0]           ex_funct3_q;
    logic [VLEN-1:0]      ex_vec_a_q;
    logic [VLEN-1:0]      ex_vec_b_q;
    logic [VLEN-1:0]      ex_vec_c_q;

    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [VLEN-1:0]      rsp_result_q;
    logic                 rsp_err_q;

    logic [NUM_REQ-1:0]   gnt_oh;
    logic [IdxW-1:0]      gnt_idx;
    logic [6:0]           sel_funct7;
    logic [2:0]           sel_funct3;
    logic [VLEN-1:0]      sel_vec_a;
    logic [VLEN-1:0]      sel_vec_b;
    logic [VLEN-1:0]      sel_vec_c;
    logic                 owner_ack;

    rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_oh),
        .idx_o (gnt_idx)
    );

    assign sel_funct7 = req_funct7_i[32'(gnt_idx) * 7 +: 7];
    assign sel_funct3 = req_funct3_i[32'(gnt_idx) * 3 +: 3];
    assign sel_vec_a  = req_vec_a_i[32'(gnt_idx) * VLEN +: VLEN];
    assign sel_vec_b  = req_vec_b_i[32'(gnt_idx) * VLEN +: VLEN];
    assign sel_vec_c  = req_vec_c_i[32'(gnt_idx) * VLEN +: VLEN];

    // Gated by reset so nothing looks accepted on an edge that reset overrides.
    assign req_ready_o = (state_q == IDLE && rst_ni) ? gnt_oh : '0;
    assign owner_ack   = |(rsp_ready_i & owner_oh_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            owner_oh_q   <= '0;
            tmo_cnt_q    <= '0;
            ex_start_q   <= 1'b0;
            ex_funct7_q  <= '0;
            ex_funct3_q  <= '0;
            ex_vec_a_q   <= '0;
            ex_vec_b_q   <= '0;
            ex_vec_c_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            ex_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req_valid_i) begin
                        ex_funct7_q <= sel_funct7;
                        ex_funct3_q <= sel_funct3;
                        ex_vec_a_q  <= sel_vec_a;
                        ex_vec_b_q  <= sel_vec_b;
                        ex_vec_c_q  <= sel_vec_c;
                        owner_q     <= gnt_idx;
                        owner_oh_q  <= gnt_oh;
                        if (is_legal_funct7(sel_funct7)) begin
                            ex_start_q <= 1'b1;
                            state_q    <= EXEC;
                        end else begin
                            rsp_result_q <= '0;
                            rsp_err_q    <= 1'b1;
                            rsp_valid_q  <= gnt_oh;
                            state_q      <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (ex_done_i) begin
                        rsp_result_q <= ex_result_i;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= owner_oh_q;
                        state_q      <= RESP;
                    end else begin
                        tmo_cnt_q <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (ex_done_i) begin
                        rsp_result_q <= ex_result_i;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= owner_oh_q;
                        state_q      <= RESP;
                    end else if (tmo_cnt_q == TmoLast) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= owner_oh_q;
                        state_q      <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (owner_ack) begin
                        rsp_valid_q <= '0;
                        rr_ptr_q    <= (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_start_o   = ex_start_q;
    assign ex_funct7_o  = ex_funct7_q;
    assign ex_funct3_o  = ex_funct3_q;
    assign ex_vec_a_o   = ex_vec_a_q;
    assign ex_vec_b_o   = ex_vec_b_q;
    assign ex_vec_c_o   = ex_vec_c_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/vector_exec_arbiter.md
Name: vector_exec_arbiter

Overview:
Shares one single-cycle vector_exec_unit between NUM_REQ independent requesters, such as the scalar-issue path and the DMA/stream path. Each request is accepted with a valid/ready handshake, and granting is round-robin. The block registers the operands, pulses start to the exec unit, and captures the result. The result is held in a response register until the owning requester accepts it. A watchdog and an illegal-funct7 check return error responses, so a requester can never hang.

Parameters:
- VLEN, 256, vector width in bits; must match the exec unit.
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 16, number of WAIT cycles without done_i before an error response; minimum 2.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, synchronous active-low reset.
- req_valid_i, in, NUM_REQ, request valid per requester.
- req_ready_o, out, NUM_REQ, request accepted; at most one bit set.
- req_funct7_i, in, NUM_REQ*7, funct7 per requester; requester r occupies slice [r*7 +: 7].
- req_funct3_i, in, NUM_REQ*3, funct3 per requester.
- req_vec_a_i / req_vec_b_i / req_vec_c_i, in, NUM_REQ*VLEN each, operands per requester.
- rsp_valid_o, out, NUM_REQ, response valid; only the owner's bit may be set.
- rsp_ready_i, in, NUM_REQ, requester accepts the response.
- rsp_result_o, out, VLEN, shared result bus; valid where rsp_valid_o is set.
- rsp_err_o, out, 1, error flag qualifying the response (illegal funct7 or timeout).
- ex_start_o, out, 1, exec-unit start pulse.
- ex_funct7_o / ex_funct3_o, out, 7/3, registered opcode to the exec unit.
- ex_vec_a_o / ex_vec_b_o / ex_vec_c_o, out, VLEN each, registered operands to the exec unit.
- ex_done_i, in, 1, exec-unit completion.
- ex_result_i, in, VLEN, exec-unit result.
- busy_o, out, 1, state is not IDLE.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs and registered operand/result fields are 0.
  - Reset mid-operation abandons the operation with no response. ex_start_o is 0 from the next cycle.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - grant = first r with req_valid_i[r]=1, searching circularly from rr_ptr.
  - req_ready_o[grant]=1 combinationally, in IDLE only.
  - On that edge the block captures the requester's funct7, funct3, a, b and c into the ex_* registers, and records owner=grant.
  - funct7 is one of `FUNCT7_VMAC/VADD/VSUB/VMUL: next state is EXEC.
  - Any other funct7: result=0, err=1, next state is RESP. The exec unit is not started.
  - No valid request: remain in IDLE.
- EXEC:
  - ex_start_o=1 for exactly this one cycle.
  - If ex_done_i=1: capture ex_result_i, set err=0, go to RESP.
  - Otherwise: clear the counter and go to WAIT.
- WAIT:
  - ex_start_o=0 and the counter increments.
  - If ex_done_i=1: capture the result, set err=0, go to RESP. If done and timeout occur in the same cycle, done wins.
  - If the counter reaches TIMEOUT_CYCLES-1 without done: result=0, err=1, go to RESP.
  - A late ex_done_i arriving after the timeout is ignored in all other states.
- RESP:
  - rsp_valid_o[owner]=1, with rsp_result_o and rsp_err_o stable and registered.
  - On rsp_ready_i[owner]=1: rr_ptr=(owner+1) mod NUM_REQ, go to IDLE.
  - rsp_ready_i bits belonging to non-owners are ignored.
- Latency and throughput:
  - For a single-cycle exec, rsp_valid_o rises 2 cycles after the accept edge.
  - Minimum issue interval is 3 cycles (IDLE→EXEC→RESP→IDLE); the block does not accept a new request while in RESP.
- Fairness:
  - A continuously requesting requester is granted at most once per NUM_REQ grants while others are requesting.
  - With a single active requester, that requester is granted on every IDLE visit.
- Stability: ex_funct7_o, ex_funct3_o and ex_vec_* stay constant from the accept edge until the next accept.

Decomposition:
- vec_ctrl_pkg holds:
  - the arb_state_e enum {IDLE, EXEC, WAIT, RESP};
  - a function is_legal_funct7(), which uses the `FUNCT7_* defines from custom_opcodes.vh;
  - the localparam width of the timeout counter.
- Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs a one-hot grant and the grant index. It is purely combinational and is instantiated once.

Test Plan:
1. Single request on port 0: `FUNCT7_VADD, a[0]=5, b[0]=7 → req_ready_o=01 and ex_start_o pulses for 1 cycle. Two cycles after accept, rsp_valid_o=01, result[31:0]=12, err=0.
2. Both ports continuously valid, port0 VMUL (3*4) and port1 VSUB (10-3), rsp_ready tied high → grants alternate 0,1,0,1. Results alternate 12 and 7.
3. Illegal funct7=7'h7F on port 1 → ex_start_o never asserts. rsp_valid_o=10, err=1, result=0.
4. Stubbed exec never asserts done, TIMEOUT_CYCLES=16 → err=1 response after 16 WAIT cycles. A later done pulse produces no extra response.
5. Backpressure: rsp_ready low for 5 cycles while port0 holds a new request → result held stable, req_ready_o=0 throughout. Next grant goes to port0 only after acceptance.
6. rst_ni=0 asserted in WAIT → the next cycle is IDLE with all outputs 0. A subsequent VMAC with a=2, b=3, c=4 returns 10.
